// File: rtl/range_record_builder.sv
// range_record_builder
// Producer side of the object-range buffer. Merges contiguous, byte-ascending
// committed stores into runs [first,last]. When a run closes with a span above
// MIN_SPAN, it emits one {first,last} record as a single-cycle strobe.
// Optional feature macro: RANGE_BUILDER_DESCEND_EN. When it is defined, a store
// that ends just below the run's first byte also extends the run downward.
//
// Handshake: en_write_o is a 1-cycle valid with no ready. The sink must accept
// the record on that cycle. addr_first_o and addr_last_o hold their value
// until the next strobe.
module range_record_builder #(
  parameter int unsigned MIN_SPAN = 20,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rst_us,
  input  logic             store_valid_i,
  input  logic [31:0]      store_addr_i,
  input  logic [1:0]       store_size_i,
  input  logic             flush_i,
  output logic             en_write_o,
  output logic [31:0]      addr_first_o,
  output logic [31:0]      addr_last_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] emit_cnt_o
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] first_q, first_d;
  logic [31:0] last_q, last_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [32:0] size_bytes;
  logic [32:0] store_end;
  logic [31:0] end_addr;
  logic        legal_store;
  logic        illegal_store;
  logic        contig;
  logic        descend;
  logic        close;
  logic [31:0] close_first;
  logic [31:0] close_last;
  logic        emit;

  // Store footprint, computed in 33 bits so a wrap past 0xFFFFFFFF is visible.
  always_comb begin
    size_bytes    = 33'd1 << store_size_i;
    store_end     = {1'b0, store_addr_i} + size_bytes - 33'd1;
    end_addr      = store_end[31:0];
    legal_store   = store_valid_i && !store_end[32];
    illegal_store = store_valid_i && store_end[32];
    contig        = legal_store && ({1'b0, store_addr_i} == ({1'b0, last_q} + 33'd1));
`ifdef RANGE_BUILDER_DESCEND_EN
    descend       = legal_store && ((store_end + 33'd1) == {1'b0, first_q});
`else
    descend       = 1'b0;
`endif
  end

  // State and run registers. rst_us takes priority over all other activity.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      first_q <= '0;
      last_q  <= '0;
      timer_q <= '0;
    end else if (rst_us) begin
      state_q <= IDLE;
      first_q <= '0;
      last_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic: run growth, run close and restart, and the idle timeout.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_d      = last_q;
    timer_d     = timer_q;
    close       = 1'b0;
    close_first = first_q;
    close_last  = last_q;
    unique case (state_q)
      IDLE: begin
        if (legal_store) begin
          first_d = store_addr_i;
          last_d  = end_addr;
          timer_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          // A store that lines up is folded in first. Any other store is dropped.
          if (contig)       close_last  = end_addr;
          else if (descend) close_first = store_addr_i;
          close   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else if (illegal_store) begin
          close   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else if (contig) begin
          last_d  = end_addr;
          timer_d = '0;
        end else if (descend) begin
          first_d = store_addr_i;
          timer_d = '0;
        end else if (legal_store) begin
          close   = 1'b1;
          first_d = store_addr_i;
          last_d  = end_addr;
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          close   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    emit = close && ((close_last - close_first) > 32'(MIN_SPAN));
  end

  // Outputs decoded from state.
  always_comb begin
    busy_o = (state_q == RUN);
  end

  // Record register: the strobe and the held addresses follow the closing edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_write_o   <= 1'b0;
      addr_first_o <= '0;
      addr_last_o  <= '0;
      emit_cnt_o   <= '0;
    end else if (rst_us) begin
      en_write_o   <= 1'b0;
      addr_first_o <= '0;
      addr_last_o  <= '0;
      emit_cnt_o   <= '0;
    end else begin
      en_write_o <= emit;
      if (emit) begin
        addr_first_o <= close_first;
        addr_last_o  <= close_last;
        if (emit_cnt_o != {CNT_W{1'b1}}) emit_cnt_o <= emit_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_range_record_builder.sv
// Testbench for range_record_builder.
// It runs directed scenarios and then a randomized store stream. The
// reference model tracks the open run as plain integers and counts idle
// cycles. Records it expects to be emitted go into exp_q.
module tb_range_record_builder;

  localparam int unsigned MIN_SPAN = 20;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned CNT_W    = 16;
`ifdef RANGE_BUILDER_DESCEND_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni;
  logic             rst_us;
  logic             store_valid;
  logic [31:0]      store_addr;
  logic [1:0]       store_size;
  logic             flush;
  logic             en_write;
  logic [31:0]      addr_first;
  logic [31:0]      addr_last;
  logic             busy;
  logic [CNT_W-1:0] emit_cnt;

  range_record_builder #(.MIN_SPAN(MIN_SPAN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .rst_us        (rst_us),
    .store_valid_i (store_valid),
    .store_addr_i  (store_addr),
    .store_size_i  (store_size),
    .flush_i       (flush),
    .en_write_o    (en_write),
    .addr_first_o  (addr_first),
    .addr_last_o   (addr_last),
    .busy_o        (busy),
    .emit_cnt_o    (emit_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0]      exp_q[$];
  bit               m_open;
  longint unsigned  m_first, m_last;
  int               m_idle;
  logic [31:0]      m_af, m_al;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void m_reset();
    m_open  = 1'b0;
    m_first = 0;
    m_last  = 0;
    m_idle  = 0;
    m_af    = '0;
    m_al    = '0;
    m_cnt   = '0;
    exp_q.delete();
  endfunction

  function automatic void m_close();
    if ((m_last - m_first) > longint'(MIN_SPAN))
      exp_q.push_back({m_first[31:0], m_last[31:0]});
    m_open = 1'b0;
    m_idle = 0;
  endfunction

  function automatic void m_start(input longint unsigned a, input longint unsigned e);
    m_open  = 1'b1;
    m_first = a;
    m_last  = e;
    m_idle  = 0;
  endfunction

  // The model applies one clock edge of inputs using the plain run rules.
  function automatic void model_step(input bit v, input logic [31:0] a, input logic [1:0] s,
                                     input bit f, input bit u);
    longint unsigned al, e;
    bit legal, con, dsc;
    if (u) begin
      m_reset();
      return;
    end
    al    = longint'(a);
    e     = al + (64'd1 << s) - 1;
    legal = (e <= 64'hFFFF_FFFF);
    if (!m_open) begin
      if (v && legal) m_start(al, e);
    end else begin
      con = v && legal && (al == m_last + 1);
      dsc = DESC && v && legal && (e + 1 == m_first);
      if (f) begin
        if (con)      m_last  = e;
        else if (dsc) m_first = al;
        m_close();
      end else if (v && !legal) begin
        m_close();
      end else if (con) begin
        m_last = e;
        m_idle = 0;
      end else if (dsc) begin
        m_first = al;
        m_idle  = 0;
      end else if (v) begin
        m_close();
        m_start(al, e);
      end else begin
        m_idle++;
        if (m_idle == int'(TIMEOUT)) m_close();
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. It drives one cycle, advances the model at the posedge,
  // checks the outputs 1 time unit later, and returns at the next negedge.
  task automatic step(input string tag, input bit v, input logic [31:0] a, input logic [1:0] s,
                      input bit f, input bit u);
    logic [63:0] rec;
    bit exp_en;
    store_valid = v;
    store_addr  = a;
    store_size  = s;
    flush       = f;
    rst_us      = u;
    @(posedge clk);
    model_step(v, a, s, f, u);
    #1;
    exp_en = 1'b0;
    if (exp_q.size() > 0) begin
      rec    = exp_q.pop_front();
      m_af   = rec[63:32];
      m_al   = rec[31:0];
      exp_en = 1'b1;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
    end
    check({tag, "_en"},    64'(en_write),   64'(exp_en));
    check({tag, "_first"}, 64'(addr_first), 64'(m_af));
    check({tag, "_last"},  64'(addr_last),  64'(m_al));
    check({tag, "_busy"},  64'(busy),       64'(m_open));
    check({tag, "_cnt"},   64'(emit_cnt),   64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic ascend_run(input string tag, input logic [31:0] base);
    for (int i = 0; i < 8; i++) step(tag, 1'b1, base + 32'(4 * i), 2'd2, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    bit          v, f, u;
    int          k;

    rst_ni      = 1'b0;
    rst_us      = 1'b0;
    store_valid = 1'b0;
    store_addr  = '0;
    store_size  = '0;
    flush       = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_en",    64'(en_write),   64'd0);
    check("rst_first", 64'(addr_first), 64'd0);
    check("rst_last",  64'(addr_last),  64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_cnt",   64'(emit_cnt),   64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Ascending run, then flush: emits (0x1000, 0x101F).
    ascend_run("t1", 32'h1000);
    step("t1_flush", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("t1_en_c",    64'(en_write),   64'd1);
    check("t1_first_c", 64'(addr_first), 64'h1000);
    check("t1_last_c",  64'(addr_last),  64'h101F);
    check("t1_cnt_c",   64'(emit_cnt),   64'd1);
    idle("t1_after");

    // A short run times out after 16 idle cycles without being emitted.
    step("t2_st", 1'b1, 32'h2000, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) idle("t2_idle");
    check("t2_busy_15", 64'(busy), 64'd1);
    idle("t2_idle16");
    check("t2_busy_16", 64'(busy),     64'd0);
    check("t2_en",      64'(en_write), 64'd0);

    // A non-contiguous store closes the run, and a new run starts from it.
    ascend_run("t3", 32'h1000);
    step("t3_new", 1'b1, 32'h3000, 2'd2, 1'b0, 1'b0);
    check("t3_en_c",    64'(en_write),   64'd1);
    check("t3_first_c", 64'(addr_first), 64'h1000);
    check("t3_last_c",  64'(addr_last),  64'h101F);
    check("t3_busy_c",  64'(busy),       64'd1);
    step("t3_flush", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("t3_flush_en", 64'(en_write), 64'd0);

    // A store that wraps past the top of the address space never starts a run.
    step("t4_wrap", 1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0, 1'b0);
    check("t4_busy", 64'(busy), 64'd0);
    idle("t4_after");

    // A synchronous clear while a run is open emits nothing and clears all outputs.
    ascend_run("t5", 32'h1000);
    step("t5_clr", 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    check("t5_cnt_c",  64'(emit_cnt), 64'd0);
    check("t5_busy_c", 64'(busy),     64'd0);
    idle("t5_after");

    // Descending fill, then flush. Whether it emits depends on the build option.
    for (int i = 7; i >= 0; i--) step("t6", 1'b1, 32'h1000 + 32'(4 * i), 2'd2, 1'b0, 1'b0);
    step("t6_flush", 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("t6_en_c", 64'(en_write), 64'(DESC));
    idle("t6_after");

    // Randomized stream.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        for (int j = 0; j < 17; j++) idle("rnd_gap");
      end
      v = ($urandom_range(0, 99) < 75);
      s = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 19);
      if (k < 13)      a = m_open ? (m_last[31:0] + 32'd1) : (32'h0001_0000 + 32'($urandom_range(0, 255)));
      else if (k < 15) a = m_first[31:0] - (32'd1 << s);
      else if (k < 17) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else             a = $urandom;
      f = ($urandom_range(0, 99) < 4);
      u = ($urandom_range(0, 299) == 0);
      step("rnd", v, a, s, f, u);
    end
    idle("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
